// File: rtl/toggle_activity_sampler.sv
// toggle_activity_sampler
//
// Counts bit toggles on a bundle of monitored nets over fixed windows of
// enabled cycles and hands each window total to a downstream sampler over a
// VALID/READY handshake with a single result register.
//
// Ports
//   CLK   in   1      clock, all state on rising edge
//   RST   in   1      asynchronous active-high reset
//   EN    in   1      sampling enable; low pauses the window
//   SIG   in   WIDTH  monitored net values
//   READY in   1      downstream accept
//   VALID out  1      COUNT/SAT hold a completed window result
//   COUNT out  CNT_W  toggles counted in the completed window (saturating)
//   SAT   out  1      COUNT saturated in that window
//   OVF   out  1      sticky: a window result was dropped under backpressure
module toggle_activity_sampler #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 256,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] SIG,
    input  logic             READY,
    output logic             VALID,
    output logic [CNT_W-1:0] COUNT,
    output logic             SAT,
    output logic             OVF
);

    localparam int TW = $clog2(WIDTH + 1);
    localparam int WW = $clog2(WINDOW);
    // Sum width covers both operands plus a carry so the limit compare happens
    // before any truncation to CNT_W.
    localparam int SW = ((CNT_W > TW) ? CNT_W : TW) + 1;
    localparam logic [SW-1:0] LIMIT = {{(SW - CNT_W){1'b0}}, {CNT_W{1'b1}}};
    localparam logic [WW-1:0] LAST  = WW'(WINDOW - 1);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic logic [TW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [TW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + TW'(v[i]);
        end
        return n;
    endfunction

    // Returns {overflowed, saturated_sum}.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [TW-1:0]    b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (s > LIMIT) begin
            return {1'b1, {CNT_W{1'b1}}};
        end
        return {1'b0, s[CNT_W-1:0]};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q;
    logic [WW-1:0]    win_q, win_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             satout_q, satout_d;
    logic             ovf_q, ovf_d;

    logic [TW-1:0]    toggles;
    logic [CNT_W:0]   sum;
    logic             count_en;
    logic             complete;

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        acc_d    = acc_q;
        sat_d    = sat_q;
        valid_d  = valid_q;
        count_d  = count_q;
        satout_d = satout_q;
        ovf_d    = ovf_q;

        toggles  = popcount(SIG ^ prev_q);
        sum      = sat_add(acc_q, toggles);
        // PRIME exists only so PREV holds a real sample before counting starts.
        count_en = (state_q == RUN) && EN;
        complete = count_en && (win_q == LAST);

        case (state_q)
            PRIME:   state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = PRIME;
        endcase

        if (count_en) begin
            if (complete) begin
                win_d = '0;
                acc_d = '0;
                sat_d = 1'b0;
            end else begin
                win_d = win_q + WW'(1);
                acc_d = sum[CNT_W-1:0];
                sat_d = sat_q | sum[CNT_W];
            end
        end

        if (complete) begin
            // An accept on the completion edge frees the slot for the new result.
            if (!valid_q || READY) begin
                valid_d  = 1'b1;
                count_d  = sum[CNT_W-1:0];
                satout_d = sat_q | sum[CNT_W];
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && READY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= PRIME;
            prev_q   <= '0;
            win_q    <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= '0;
            satout_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= SIG;
            win_q    <= win_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            satout_q <= satout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign VALID = valid_q;
    assign COUNT = count_q;
    assign SAT   = satout_q;
    assign OVF   = ovf_q;

endmodule
